// File: rtl/cdb_arbiter_pkg.sv
// Common-data-bus payload type shared by the arbiter, its interface and users.
package cdb_arbiter_pkg;

  localparam int unsigned TAG_W  = 6;
  localparam int unsigned DATA_W = 32;

  // One CDB broadcast: qualifier, producing reservation-station tag, result value
  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] rd_v;
  } cdb_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Requester/CDB bundle between the functional units and the CDB arbiter.
interface cdb_arbiter_if #(
  parameter int unsigned NUM_REQ = 5
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic                                  flush;
  logic [NUM_REQ-1:0]                    req_valid;
  cdb_arbiter_pkg::cdb_t [NUM_REQ-1:0]   req_data;
  logic [NUM_REQ-1:0]                    req_ready;
  cdb_arbiter_pkg::cdb_t                 cdb_out;
  logic [IDX_W-1:0]                      grant_idx;

  modport master (
    output flush, req_valid, req_data,
    input  req_ready, cdb_out, grant_idx
  );

  modport slave (
    input  flush, req_valid, req_data,
    output req_ready, cdb_out, grant_idx
  );

endinterface

// File: rtl/cdb_arbiter.sv
// CDB arbiter: picks one functional-unit result per cycle and broadcasts it
// on the registered common data bus one cycle later.
// Build option: define CDB_ROUND_ROBIN_EN for round-robin priority; otherwise
// the lowest valid index always wins and no rotation pointer exists.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 5
) (
  input  logic                clk,
  input  logic                rst,
  cdb_arbiter_if.slave        bus
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  logic [NUM_REQ-1:0] ready_c;
  logic [IDX_W-1:0]   win_c;
  logic [IDX_W-1:0]   cand_c;
  logic               xfer_c;
  cdb_t               pick_c;

  cdb_t               cdb_q;
  logic [IDX_W-1:0]   gidx_q;

`ifdef CDB_ROUND_ROBIN_EN
  localparam int unsigned SUM_W = IDX_W + 1;
  logic [IDX_W-1:0]   ptr;
  logic [SUM_W-1:0]   sum_c;
`endif

  // Search the requesters from the priority start point and grant the first valid one
  always_comb begin
    ready_c = '0;
    win_c   = '0;
    cand_c  = '0;
    xfer_c  = 1'b0;
`ifdef CDB_ROUND_ROBIN_EN
    sum_c   = '0;
`endif
    if (!rst && !bus.flush) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
`ifdef CDB_ROUND_ROBIN_EN
        sum_c = {1'b0, ptr} + SUM_W'(k);
        if (sum_c >= SUM_W'(NUM_REQ)) begin
          sum_c = sum_c - SUM_W'(NUM_REQ);
        end
        cand_c = sum_c[IDX_W-1:0];
`else
        cand_c = IDX_W'(k);
`endif
        if (!xfer_c && bus.req_valid[cand_c]) begin
          xfer_c = 1'b1;
          win_c  = cand_c;
        end
      end
    end
    ready_c[win_c] = xfer_c;
  end

  // Winning payload with the bus qualifier forced on
  always_comb begin
    pick_c       = bus.req_data[win_c];
    pick_c.valid = 1'b1;
  end

  // Broadcast register and rotation pointer; flush and reset both drop the bus
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      cdb_q  <= '0;
      gidx_q <= '0;
`ifdef CDB_ROUND_ROBIN_EN
      ptr    <= '0;
`endif
    end else if (xfer_c) begin
      cdb_q  <= pick_c;
      gidx_q <= win_c;
`ifdef CDB_ROUND_ROBIN_EN
      ptr    <= (win_c == LAST_IDX) ? '0 : win_c + IDX_W'(1);
`endif
    end else begin
      cdb_q  <= '0;
      gidx_q <= '0;
    end
  end

  assign bus.req_ready = ready_c;
  assign bus.cdb_out   = cdb_q;
  assign bus.grant_idx = gidx_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed table, corner sequences and
// randomized traffic against a queue-level reference model.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int N = 5;
`ifdef CDB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cdb_arbiter_if #(.NUM_REQ(N)) bus ();
  cdb_arbiter #(.NUM_REQ(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [N-1:0] valid;
    logic [N-1:0] exp_ready;
    logic         exp_valid;
    int           exp_idx;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs just after the falling edge
  task automatic apply(input logic r, input logic f, input logic [N-1:0] v);
    @(negedge clk);
    rst = r;
    bus.flush = f;
    bus.req_valid = v;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int i, input logic [31:0] d);
    bus.req_data[i] = '{valid: 1'b1, tag: 6'(i), rd_v: d};
  endtask

  // reference model state for randomized traffic
  bit   pend[N];
  cdb_t pay[N];
  int   waitc[N];
  int   bc[N];
  int   mptr;
  int   tagc;

  initial begin
    int g, start, idx;
    logic r, f;
    logic [N-1:0] expr;
    logic [N-1:0] vbits;
    cdb_t expc;

    rst = 1'b1;
    bus.flush = 1'b0;
    bus.req_valid = '0;
    for (int i = 0; i < N; i++) set_data(i, 32'h0);

    tbl[0] = '{5'b00001, 5'b00001, 1'b1, 0};
    tbl[1] = '{5'b10110, 5'b00010, 1'b1, 1};
    tbl[2] = '{5'b11111, 5'b00001, 1'b1, 0};
    tbl[3] = '{5'b10000, 5'b10000, 1'b1, 4};
    tbl[4] = '{5'b00000, 5'b00000, 1'b0, 0};
    tbl[5] = '{5'b01000, 5'b01000, 1'b1, 3};
    tbl[6] = '{5'b11100, 5'b00100, 1'b1, 2};
    tbl[7] = '{5'b01010, 5'b00010, 1'b1, 1};

    // reset state
    apply(1'b1, 1'b0, 5'b11111);
    chk("reset_ready", 64'(bus.req_ready), 64'(0));
    tick();
    chk("reset_cdb", 64'(bus.cdb_out), 64'(0));
    chk("reset_gidx", 64'(bus.grant_idx), 64'(0));

    // single requester, back-to-back transfers
    set_data(0, 32'h1234);
    for (int c = 0; c < 3; c++) begin
      apply(1'b0, 1'b0, 5'b00001);
      chk("single_ready", 64'(bus.req_ready), 64'(5'b00001));
      tick();
      chk("single_valid", 64'(bus.cdb_out.valid), 64'(1));
      chk("single_data", 64'(bus.cdb_out.rd_v), 64'(32'h1234));
      chk("single_gidx", 64'(bus.grant_idx), 64'(0));
    end

    // directed table, each row preceded by a flush so priority starts at 0
    for (int row = 0; row < 8; row++) begin
      for (int i = 0; i < N; i++) set_data(i, 32'hA000_0000 + 32'(row * 16 + i));
      apply(1'b0, 1'b1, tbl[row].valid);
      chk("tbl_flush_ready", 64'(bus.req_ready), 64'(0));
      tick();
      chk("tbl_flush_valid", 64'(bus.cdb_out.valid), 64'(0));
      apply(1'b0, 1'b0, tbl[row].valid);
      chk("tbl_ready", 64'(bus.req_ready), 64'(tbl[row].exp_ready));
      tick();
      chk("tbl_valid", 64'(bus.cdb_out.valid), 64'(tbl[row].exp_valid));
      chk("tbl_gidx", 64'(bus.grant_idx), 64'(tbl[row].exp_idx));
      if (tbl[row].exp_valid)
        chk("tbl_data", 64'(bus.cdb_out.rd_v), 64'(32'hA000_0000 + 32'(row * 16 + tbl[row].exp_idx)));
    end

    // all requesters held for 10 cycles
    apply(1'b0, 1'b1, 5'b00000);
    tick();
    for (int i = 0; i < N; i++) bc[i] = 0;
    for (int c = 0; c < 10; c++) begin
      apply(1'b0, 1'b0, 5'b11111);
      chk("all_ready", 64'(bus.req_ready), 64'(5'(1) << (RR ? c % N : 0)));
      tick();
      chk("all_gidx", 64'(bus.grant_idx), 64'(RR ? c % N : 0));
      if (bus.cdb_out.valid) bc[bus.grant_idx]++;
    end
    for (int i = 0; i < N; i++)
      chk("all_count", 64'(bc[i]), 64'(RR ? 2 : (i == 0 ? 10 : 0)));

    // sparse pattern 10110 held 3 cycles
    apply(1'b0, 1'b1, 5'b00000);
    tick();
    for (int c = 0; c < 3; c++) begin
      apply(1'b0, 1'b0, 5'b10110);
      idx = RR ? (c == 0 ? 1 : (c == 1 ? 2 : 4)) : 1;
      chk("sparse_ready", 64'(bus.req_ready), 64'(5'(1) << idx));
      tick();
      chk("sparse_gidx", 64'(bus.grant_idx), 64'(idx));
    end

    // flush right after a transfer from index 2
    apply(1'b0, 1'b1, 5'b00000);
    tick();
    apply(1'b0, 1'b0, 5'b00100);
    chk("fl_ready2", 64'(bus.req_ready), 64'(5'b00100));
    tick();
    chk("fl_gidx2", 64'(bus.grant_idx), 64'(2));
    apply(1'b0, 1'b1, 5'b11111);
    chk("fl_ready_zero", 64'(bus.req_ready), 64'(0));
    chk("fl_shown2", 64'(bus.cdb_out.valid), 64'(1));
    tick();
    chk("fl_dropped", 64'(bus.cdb_out.valid), 64'(0));
    apply(1'b0, 1'b0, 5'b11111);
    chk("fl_ready0", 64'(bus.req_ready), 64'(5'b00001));
    tick();
    chk("fl_gidx0", 64'(bus.grant_idx), 64'(0));

    // reset pulse with a broadcast in flight
    apply(1'b0, 1'b0, 5'b01000);
    tick();
    apply(1'b1, 1'b0, 5'b01000);
    chk("rp_ready", 64'(bus.req_ready), 64'(0));
    tick();
    chk("rp_cdb", 64'(bus.cdb_out), 64'(0));
    chk("rp_gidx", 64'(bus.grant_idx), 64'(0));
    apply(1'b0, 1'b0, 5'b01000);
    chk("rp_ready3", 64'(bus.req_ready), 64'(5'b01000));
    tick();
    chk("rp_gidx3", 64'(bus.grant_idx), 64'(3));
    chk("rp_valid3", 64'(bus.cdb_out.valid), 64'(1));

    // randomized traffic against the reference model
    apply(1'b0, 1'b1, 5'b00000);
    tick();
    mptr = 0;
    tagc = 0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0;
      waitc[i] = 0;
      pay[i] = '0;
    end
    for (int cyc = 0; cyc < 4000; cyc++) begin
      r = ($urandom_range(0, 127) == 0);
      f = !r && ($urandom_range(0, 63) == 0);
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i] = 1'b1;
          pay[i] = '{valid: 1'b1, tag: 6'(tagc), rd_v: $urandom};
          tagc++;
        end
        vbits[i] = pend[i];
      end
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (pend[i]) bus.req_data[i] = pay[i];
        else         bus.req_data[i] = cdb_t'({$urandom, $urandom});
      end
      rst = r;
      bus.flush = f;
      bus.req_valid = vbits;
      #1;
      g = -1;
      start = RR ? mptr : 0;
      if (!r && !f) begin
        for (int k = 0; k < N; k++) begin
          idx = (start + k) % N;
          if (g < 0 && pend[idx]) g = idx;
        end
      end
      expr = (g >= 0) ? (5'(1) << g) : '0;
      chk("rand_ready", 64'(bus.req_ready), 64'(expr));
      tick();
      if (g >= 0) begin
        expc = pay[g];
        chk("rand_cdb", 64'(bus.cdb_out), 64'(expc));
        chk("rand_gidx", 64'(bus.grant_idx), 64'(g));
      end else begin
        chk("rand_idle_valid", 64'(bus.cdb_out.valid), 64'(0));
        chk("rand_idle_gidx", 64'(bus.grant_idx), 64'(0));
      end
      for (int i = 0; i < N; i++) begin
        if (r || f) waitc[i] = 0;
        else if (i == g) begin
          if (RR) chk("rand_starve", 64'(waitc[i] < N), 64'(1));
          waitc[i] = 0;
        end else if (pend[i]) waitc[i]++;
      end
      if (g >= 0) begin
        pend[g] = 1'b0;
        mptr = (g + 1) % N;
      end else if (r || f) begin
        mptr = 0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
